// File: rtl/nanov_digit_alu.sv
// nanov_digit_alu: digit-serial RV32 ALU, DIGIT bits per cycle LSB first, with start/busy/done handshake
module nanov_digit_alu #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int SW = $clog2(XLEN);
  localparam int K  = XLEN / DIGIT;
  localparam int IW = $clog2(K) + 1;

  typedef enum logic [1:0] {IDLE, ARITH, SHIFT} state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, acc, acc_n, arith_res, w_d, w_1, work_n;
  logic [DIGIT-1:0] ad, bd, dres;
  logic [DIGIT:0]  dsum;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   n, n_n;
  logic [2:0]      f3;
  logic            carry, sa, sb, inv, lt, fb, big, left, last;

  function automatic logic sub_like(input logic [3:0] o);
    return (o[2:0] == 3'b000 && o[3]) || o[2:0] == 3'b010 || o[2:0] == 3'b011;
  endfunction

  // a_q/b_q shift right each ARITH cycle so the live digit is always at bit 0;
  // in SHIFT a_q doubles as the working register
  always_comb begin
    f3        = op_q[2:0];
    inv       = sub_like(op_q);
    ad        = a_q[DIGIT-1:0];
    bd        = b_q[DIGIT-1:0] ^ {DIGIT{inv}};
    dsum      = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, carry};
    dres      = f3 == 3'b100 ? ad ^ bd : f3 == 3'b110 ? ad | bd : f3 == 3'b111 ? ad & bd : dsum[DIGIT-1:0];
    acc_n     = (acc >> DIGIT) | (XLEN'(dres) << (XLEN - DIGIT));
    last      = idx == IW'(K - 1);
    lt        = (sa ^ sb) ? sa : dsum[DIGIT-1];
    arith_res = f3 == 3'b010 ? {{(XLEN-1){1'b0}}, lt} :
                f3 == 3'b011 ? {{(XLEN-1){1'b0}}, ~dsum[DIGIT]} : acc_n;
    left      = f3 == 3'b001;
    fb        = op_q[3] & a_q[XLEN-1] & ~left;
    big       = {1'b0, n} >= (SW+1)'(DIGIT);
    w_d       = left ? a_q << DIGIT : (a_q >> DIGIT) | ({XLEN{fb}} & ~({XLEN{1'b1}} >> DIGIT));
    w_1       = left ? a_q << 1 : {fb, a_q[XLEN-1:1]};
    work_n    = big ? w_d : n != '0 ? w_1 : a_q;
    n_n       = big ? n - SW'(DIGIT) : n != '0 ? n - SW'(1) : n;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      idx    <= '0;
      n      <= '0;
      carry  <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          a_q   <= a;
          b_q   <= b;
          n     <= b[SW-1:0];
          carry <= sub_like(op);
          sa    <= a[XLEN-1];
          sb    <= b[XLEN-1];
          idx   <= '0;
          acc   <= '0;
          busy  <= 1'b1;
          state <= (op[2:0] == 3'b001 || op[2:0] == 3'b101) ? SHIFT : ARITH;
        end
        ARITH: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          acc   <= acc_n;
          carry <= dsum[DIGIT];
          idx   <= idx + IW'(1);
          if (last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= arith_res;
          end
        end
        SHIFT: begin
          a_q <= work_n;
          n   <= n_n;
          if (n_n == '0) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= work_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nanov_digit_alu.sv
// tb_nanov_digit_alu: six ALU instances (DIGIT=1..32) checked by a result/latency scoreboard
module tb_nanov_digit_alu;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_v [6];
  logic [3:0]  op_v [6];
  logic [31:0] a_v [6];
  logic [31:0] b_v [6];
  logic [31:0] result_v [6];
  logic        busy_v [6];
  logic        done_v [6];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {int k; logic [31:0] res; int edge_n;} exp_t;
  typedef struct {int k; logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res;} vec_t;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 6; g++) begin : u
    nanov_digit_alu #(.XLEN(32), .DIGIT(1 << g)) dut (
      .clk(clk), .rstn(rstn), .start(start_v[g]), .op(op_v[g]), .a(a_v[g]), .b(b_v[g]),
      .busy(busy_v[g]), .done(done_v[g]), .result(result_v[g])
    );
  end

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic [4:0] sh;
    logic [31:0] r;
    sx = x;
    sh = y[4:0];
    case (o[2:0])
      3'd0: r = o[3] ? x - y : x + y;
      3'd1: r = x << sh;
      3'd2: r = {31'b0, $signed(x) < $signed(y)};
      3'd3: r = {31'b0, x < y};
      3'd4: r = x ^ y;
      3'd5: if (o[3]) r = sx >>> sh; else r = x >> sh;
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [3:0] o, input logic [31:0] y, input int d);
    int s;
    s = int'(y[4:0]);
    if (o[2:0] == 3'd1 || o[2:0] == 3'd5) return (s / d + s % d) > 1 ? s / d + s % d : 1;
    return 32 / d;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, k, act, exp);
    end
  endtask

  task automatic issue(input int k, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    @(negedge clk);
    start_v[k] = 1'b1;
    op_v[k] = o;
    a_v[k] = x;
    b_v[k] = y;
    sb.push_back('{k, e, cyc + 1 + lat(o, y, 1 << k)});
    @(negedge clk);
    start_v[k] = 1'b0;
    a_v[k] = $urandom;
    b_v[k] = $urandom;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // scoreboard: every done must match the oldest pending op, in value and in edge number
  always @(negedge clk) begin
    if (rstn) begin
      for (int k = 0; k < 6; k++) begin
        chk("busy_done_excl", k, {31'b0, busy_v[k] & done_v[k]}, 32'h0);
        if (done_v[k]) begin
          if (sb.size() == 0 || sb[0].k != k) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done dut%0d: got done=1 at edge %0d, expected none", k, cyc);
          end else begin
            chk("result", k, result_v[k], sb[0].res);
            chk("latency", k, 32'(cyc), 32'(sb[0].edge_n));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 6; k++) begin
      start_v[k] = 1'b0;
      op_v[k] = 4'h0;
      a_v[k] = '0;
      b_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("rst_busy", k, {31'b0, busy_v[k]}, 32'h0);
      chk("rst_done", k, {31'b0, done_v[k]}, 32'h0);
      chk("rst_result", k, result_v[k], 32'h0);
    end
    rstn = 1'b1;

    vecs.push_back('{0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{2, 4'b1000, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE});
    vecs.push_back('{2, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
    vecs.push_back('{2, 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{2, 4'b1101, 32'h8000_0000, 32'h0000_0005, 32'hFC00_0000});
    vecs.push_back('{2, 4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000});
    vecs.push_back('{2, 4'b0101, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678});
    vecs.push_back('{1, 4'b0100, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA});
    vecs.push_back('{1, 4'b1100, 32'h0000_0001, 32'h0000_0003, 32'h0000_0002});
    vecs.push_back('{1, 4'b0110, 32'h00FF_0000, 32'h0000_FF00, 32'h00FF_FF00});
    vecs.push_back('{3, 4'b0010, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{3, 4'b1011, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001});
    vecs.push_back('{4, 4'b1101, 32'hF000_0000, 32'h0000_0014, 32'hFFFF_FF00});
    vecs.push_back('{5, 4'b0000, 32'h0000_0007, 32'h0000_0008, 32'h0000_000F});
    vecs.push_back('{5, 4'b0001, 32'h0000_0001, 32'h0000_0003, 32'h0000_0008});
    vecs.push_back('{5, 4'b0101, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF});
    foreach (vecs[i]) begin
      issue(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
      drain();
    end

    // start held high with operands churning while busy, released before done
    @(negedge clk);
    start_v[3] = 1'b1;
    op_v[3] = 4'b0111;
    a_v[3] = 32'hF0F0_1234;
    b_v[3] = 32'h0FF0_FF00;
    sb.push_back('{3, 32'h00F0_1200, cyc + 1 + 4});
    repeat (3) begin
      @(negedge clk);
      a_v[3] = $urandom;
      b_v[3] = $urandom;
      op_v[3] = 4'($urandom);
    end
    @(negedge clk);
    start_v[3] = 1'b0;
    for (int i = 0; i < 10 && !done_v[3]; i++) @(negedge clk);
    chk("b2b_done_seen", 3, {31'b0, done_v[3]}, 32'h1);
    start_v[3] = 1'b1;
    op_v[3] = 4'b1000;
    a_v[3] = 32'd100;
    b_v[3] = 32'd1;
    sb.push_back('{3, 32'd99, cyc + 1 + 4});
    @(negedge clk);
    start_v[3] = 1'b0;
    drain();

    // asynchronous reset in the middle of a DIGIT=2 add
    issue(1, 4'b0000, 32'h0000_1234, 32'h0000_0001, 32'h0000_1235);
    repeat (5) @(negedge clk);
    chk("busy_mid_op", 1, {31'b0, busy_v[1]}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("arst_busy", 1, {31'b0, busy_v[1]}, 32'h0);
    chk("arst_done", 1, {31'b0, done_v[1]}, 32'h0);
    chk("arst_result", 1, result_v[1], 32'h0);
    sb.delete();
    #3 rstn = 1'b1;
    repeat (40) @(negedge clk);
    issue(1, 4'b0000, 32'd5, 32'd6, 32'd11);
    drain();

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 12; i++) begin
        logic [3:0] o;
        logic [31:0] x, y;
        o = 4'($urandom_range(0, 15));
        x = $urandom;
        y = $urandom;
        issue(k, o, x, y, model(o, x, y));
        drain();
      end
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
